nios2_jtag_debug_sysclk_bridge: RTL and testbench

System-clock side of the Nios II JTAG debug bridge, a parametrised successor of the fixed 2-bit-IR / 38-bit-DR sysclk decoder.
- Synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) into clk and captures the TCK-domain shift register.
- Decodes the captured instruction into one-hot take_action / take_no_action strobes.
- Adds a cmd_ready back-pressure handshake, sticky overrun detection and an issued-command counter.
- Sits between the TCK-domain debug shift logic and the OCI debug units (break, ocimem, trace).

---
 rtl/nios2_jtag_debug_sysclk_bridge.sv | 67 ++++++
 tb/tb_nios2_jtag_debug_sysclk_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nios2_jtag_debug_sysclk_bridge.sv
// nios2_jtag_debug_sysclk_bridge: syncs JTAG update strobes into clk, captures the DR and issues one-hot action strobes with back-pressure
module nios2_jtag_debug_sysclk_bridge #(
  parameter int DR_W = 38,
  parameter int IR_W = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT = 35,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DR_W-1:0]      sr,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic                 cmd_ready,
  input  logic                 overrun_clr,
  output logic [DR_W-1:0]      jdo,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [2**IR_W-1:0]   take_action,
  output logic [2**IR_W-1:0]   take_no_action,
  output logic                 cmd_pending,
  output logic                 overrun,
  output logic [CNT_W-1:0]     cmd_count
);
  localparam int NA = 2**IR_W;
  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic uir_d, udr_d;
  logic [IR_W-1:0] ir_cur;
  logic uir_p, udr_p, issue;
  always_comb begin
    uir_p = uir_sync[SYNC_STAGES-1] & ~uir_d;
    udr_p = udr_sync[SYNC_STAGES-1] & ~udr_d;
    issue = cmd_pending & cmd_ready;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_d <= 1'b0;
      udr_d <= 1'b0;
      ir_cur <= '0;
      jdo <= '0;
      cmd_ir <= '0;
      take_action <= '0;
      take_no_action <= '0;
      cmd_pending <= 1'b0;
      overrun <= 1'b0;
      cmd_count <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_d <= uir_sync[SYNC_STAGES-1];
      udr_d <= udr_sync[SYNC_STAGES-1];
      if (uir_p) ir_cur <= ir_in;
      // strobes read the old jdo/cmd_ir, so a same-cycle capture never corrupts an issue
      take_action <= (issue && jdo[ACT_BIT]) ? NA'(1) << cmd_ir : '0;
      take_no_action <= (issue && !jdo[ACT_BIT]) ? NA'(1) << cmd_ir : '0;
      if (issue) cmd_count <= cmd_count + CNT_W'(1);
      if (udr_p) begin
        jdo <= sr;
        cmd_ir <= uir_p ? ir_in : ir_cur;
      end
      cmd_pending <= udr_p | (cmd_pending & ~cmd_ready);
      overrun <= (udr_p & cmd_pending & ~cmd_ready) | (overrun & ~overrun_clr);
    end
  end
endmodule

// File: tb/tb_nios2_jtag_debug_sysclk_bridge.sv
// tb_nios2_jtag_debug_sysclk_bridge: directed stimulus with a strobe scoreboard
module tb_nios2_jtag_debug_sysclk_bridge;
  logic clk, reset_n, vs_uir, vs_udr, cmd_ready, overrun_clr;
  logic [1:0] ir_in, cmd_ir;
  logic [37:0] sr, jdo;
  logic [3:0] take_action, take_no_action, cmd_count;
  logic cmd_pending, overrun;
  int checks = 0, passes = 0, fails = 0;
  logic [7:0] sb[$];

  nios2_jtag_debug_sysclk_bridge #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir),
    .vs_udr(vs_udr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .jdo(jdo), .cmd_ir(cmd_ir), .take_action(take_action),
    .take_no_action(take_no_action), .cmd_pending(cmd_pending),
    .overrun(overrun), .cmd_count(cmd_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_strobe(input logic [1:0] ir, input logic [37:0] d);
    logic [3:0] oh;
    oh = 4'b1 << ir;
    return d[35] ? {oh, 4'b0} : {4'b0, oh};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [1:0] v);
    ir_in = v;
    vs_uir = 1;
    step(4);
    vs_uir = 0;
    step(4);
  endtask

  task automatic capture(input logic [37:0] d);
    sr = d;
    vs_udr = 1;
    step(4);
    vs_udr = 0;
    step(4);
  endtask

  // every strobe seen must match the next queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (|{take_action, take_no_action}) begin
        check("strobe_exclusive", 64'(take_action & take_no_action), 64'(0));
        if (sb.size() == 0) check("unexpected_strobe", 64'({take_action, take_no_action}), 64'(0));
        else check("strobe", 64'({take_action, take_no_action}), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 0; vs_uir = 0; vs_udr = 0; cmd_ready = 0; overrun_clr = 0;
    ir_in = 0; sr = 0;
    step(3);
    check("rst_outputs", 64'({jdo, cmd_ir, take_action, take_no_action, cmd_pending, overrun, cmd_count}), 64'(0));
    sr = 38'h3f_ffff_ffff;
    for (int i = 0; i < 4; i++) begin
      vs_udr = ~vs_udr;
      step(2);
    end
    check("rst_no_capture", 64'({jdo, cmd_pending}), 64'(0));
    vs_udr = 0;
    step(4);
    reset_n = 1;
    step(4);
    check("post_rst_pending", 64'(cmd_pending), 64'(0));

    cmd_ready = 1;
    set_ir(2'b01);
    sr = 38'h08_0000_1234;
    sb.push_back(exp_strobe(2'b01, sr));
    vs_udr = 1;
    step(3);
    check("basic_jdo", 64'(jdo), 64'(38'h08_0000_1234));
    check("basic_pending", 64'(cmd_pending), 64'(1));
    check("basic_no_early", 64'(take_action), 64'(0));
    step(1);
    check("basic_ta", 64'(take_action), 64'(4'b0010));
    check("basic_count", 64'(cmd_count), 64'(1));
    step(1);
    check("basic_one_cycle", 64'(take_action), 64'(0));
    step(2);
    vs_udr = 0;
    step(4);
    check("basic_count_hold", 64'(cmd_count), 64'(1));

    cmd_ready = 0;
    set_ir(2'b11);
    sr = 38'h00_0000_00ab;
    sb.push_back(exp_strobe(2'b11, sr));
    vs_udr = 1;
    step(4);
    vs_udr = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_pending", 64'(cmd_pending), 64'(1));
      check("bp_no_strobe", 64'({take_action, take_no_action}), 64'(0));
    end
    cmd_ready = 1;
    step(1);
    check("bp_tna", 64'(take_no_action), 64'(4'b1000));
    check("bp_count", 64'(cmd_count), 64'(2));
    step(1);
    check("bp_released", 64'(cmd_pending), 64'(0));

    cmd_ready = 0;
    capture(38'h1);
    check("ovr_first_clear", 64'(overrun), 64'(0));
    capture(38'h2);
    check("ovr_set", 64'(overrun), 64'(1));
    check("ovr_jdo", 64'(jdo), 64'(38'h2));
    sb.push_back(exp_strobe(2'b11, 38'h2));
    cmd_ready = 1;
    step(1);
    check("ovr_count", 64'(cmd_count), 64'(3));
    step(1);
    check("ovr_sticky", 64'({cmd_pending, overrun}), 64'(2'b01));
    overrun_clr = 1;
    step(1);
    overrun_clr = 0;
    check("ovr_clr", 64'(overrun), 64'(0));

    cmd_ready = 0;
    capture(38'h08_0000_0c0c);
    sb.push_back(exp_strobe(2'b11, 38'h08_0000_0c0c));
    sb.push_back(exp_strobe(2'b11, 38'h0d));
    sr = 38'h0d;
    vs_udr = 1;
    step(2);
    cmd_ready = 1;
    step(1);
    check("sim_old_strobe", 64'(take_action), 64'(4'b1000));
    check("sim_new_jdo", 64'(jdo), 64'(38'h0d));
    check("sim_pending", 64'(cmd_pending), 64'(1));
    check("sim_no_overrun", 64'(overrun), 64'(0));
    step(1);
    check("sim_second", 64'(take_no_action), 64'(4'b1000));
    vs_udr = 0;
    step(4);
    check("sim_count", 64'(cmd_count), 64'(5));

    reset_n = 0;
    #1;
    check("rst_async", 64'({cmd_count, cmd_pending, jdo}), 64'(0));
    step(2);
    reset_n = 1;
    step(2);
    set_ir(2'b01);
    for (int i = 0; i < 17; i++) begin
      logic [37:0] d;
      d = {2'b00, 1'(i & 1), 35'(i)};
      sb.push_back(exp_strobe(2'b01, d));
      capture(d);
    end
    check("wrap_count", 64'(cmd_count), 64'(1));

    sr = 38'h08_0000_0001;
    vs_udr = 1;
    step(1);
    reset_n = 0;
    step(1);
    vs_udr = 0;
    reset_n = 1;
    step(6);
    check("midsync_pending", 64'(cmd_pending), 64'(0));
    check("midsync_count", 64'(cmd_count), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
